// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// image framing constants and a small state classification helper.
package imem_loader_pkg;

    // Loader states; LEN/DATA/CHK are the "loading" states that accept bytes.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Length header is a 4-byte little-endian word.
    localparam int LEN_BYTES = 4;
    localparam int LEN_IDX_W = $clog2(LEN_BYTES);

    // Checksum (and stream byte) width.
    localparam int CHK_W = 8;

    // True while a load is in progress and the stream is being consumed.
    function automatic logic is_loading(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream (valid/ready) in, instruction-memory byte write port out.
// slave  : the loader (consumes the stream, drives the write port)
// master : the host/front-end side (drives the stream, observes the writes)
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic [CHK_W-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             wr_en;
    logic [31:0]      wr_addr;
    logic [CHK_W-1:0] wr_data;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/imem_loader_watchdog.sv
// Idle watchdog for the loader: counts consecutive enabled cycles without a
// clear and emits a one-cycle expired pulse on the TIMEOUT-th such cycle.
module imem_loader_watchdog #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Next count and expiry: held at zero while disabled or cleared.
    always_comb begin
        count_next = count_reg;
        expired    = 1'b0;
        if (!enable || clear) begin
            count_next = '0;
        end else if (count_reg == CNT_W'(TIMEOUT - 1)) begin
            expired    = 1'b1;
            count_next = '0;
        end else begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    // Idle-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a framed program image on a byte stream
// (4-byte LE length, payload, 8-bit additive checksum), writes the payload into
// instruction memory and releases the core from reset once the image checks out.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEMORY_SIZE = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          TIMEOUT     = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [31:0]         byte_count
);

    state_t                 state_reg,   state_next;
    logic [31:0]            len_reg,     len_next;
    logic [LEN_IDX_W-1:0]   len_cnt_reg, len_cnt_next;
    logic [31:0]            idx_reg,     idx_next;
    logic [CHK_W-1:0]       chk_reg,     chk_next;
    logic                   wr_en_reg,   wr_en_next;
    logic [31:0]            wr_addr_reg, wr_addr_next;
    logic [CHK_W-1:0]       wr_data_reg, wr_data_next;

    logic                   rx_ready_w;
    logic                   xfer;
    logic                   wd_expired;
    logic [31:0]            len_shift;

    // Stream acceptance is a pure function of state (Moore ready).
    assign rx_ready_w = is_loading(state_reg);
    assign xfer       = bus.rx_valid & rx_ready_w;

    // Length word with the incoming byte shifted in at the top; after four
    // shifts the first-received byte lands in bits [7:0].
    generate
        for (genvar gi = 0; gi < LEN_BYTES - 1; gi++) begin : g_len_shift
            assign len_shift[gi*8 +: 8] = len_reg[(gi+1)*8 +: 8];
        end
    endgenerate
    assign len_shift[31:24] = bus.rx_data;

    imem_loader_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (xfer),
        .enable  (rx_ready_w),
        .expired (wd_expired)
    );

    // Next-state and datapath updates for the load sequence.
    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        len_cnt_next = len_cnt_reg;
        idx_next     = idx_reg;
        chk_next     = chk_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next   = ST_LEN;
                    len_next     = '0;
                    len_cnt_next = '0;
                    idx_next     = '0;
                    chk_next     = '0;
                end
            end

            ST_LEN: begin
                if (wd_expired) begin
                    state_next = ST_ERR;
                end else if (xfer) begin
                    len_next     = len_shift;
                    len_cnt_next = len_cnt_reg + LEN_IDX_W'(1);
                    if (len_cnt_reg == LEN_IDX_W'(LEN_BYTES - 1)) begin
                        // Oversized images are rejected before any write.
                        if (len_shift > 32'(MEMORY_SIZE)) begin
                            state_next = ST_ERR;
                        end else if (len_shift == 32'd0) begin
                            state_next = ST_CHK;
                        end else begin
                            state_next = ST_DATA;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (wd_expired) begin
                    state_next = ST_ERR;
                end else if (xfer) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = BASE_ADDR + idx_reg;
                    wr_data_next = bus.rx_data;
                    idx_next     = idx_reg + 32'd1;
                    chk_next     = chk_reg + bus.rx_data;
                    if (idx_reg + 32'd1 == len_reg) begin
                        state_next = ST_CHK;
                    end
                end
            end

            ST_CHK: begin
                if (wd_expired) begin
                    state_next = ST_ERR;
                end else if (xfer) begin
                    state_next = (bus.rx_data == chk_reg) ? ST_DONE : ST_ERR;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns everything to idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            len_reg     <= '0;
            len_cnt_reg <= '0;
            idx_reg     <= '0;
            chk_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            len_cnt_reg <= len_cnt_next;
            idx_reg     <= idx_next;
            chk_reg     <= chk_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    assign bus.rx_ready = rx_ready_w;
    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_data  = wr_data_reg;

    // Core is only released after a clean load.
    assign cpu_hold   = (state_reg != ST_DONE);
    assign done       = (state_reg == ST_DONE);
    assign error      = (state_reg == ST_ERR);
    assign byte_count = idx_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives framed images over the byte stream,
// scoreboards the memory writes and checks the status outputs.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int          TO   = 64;
    localparam logic [31:0] BASE = 32'h0;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [31:0] byte_count;

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t sb[$];
    wr_t exp_w;

    imem_loader_if bus();

    imem_loader #(
        .MEMORY_SIZE (1024),
        .BASE_ADDR   (BASE),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write",
                       bus.wr_addr, bus.wr_data);
            end else begin
                exp_w = sb.pop_front();
                check("wr_addr", bus.wr_addr, exp_w.addr);
                check("wr_data", {24'h0, bus.wr_data}, {24'h0, exp_w.data});
                $display("write addr=%h data=%h", bus.wr_addr, bus.wr_data);
            end
        end
    end

    // Present a byte and hold it until the loader accepts it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", {31'h0, bus.rx_ready}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) begin
            send_byte(n[i*8 +: 8]);
        end
    endtask

    task automatic send_data(input int idx, input logic [7:0] b);
        wr_t w;
        w.addr = BASE + 32'(idx);
        w.data = b;
        sb.push_back(w);
        send_byte(b);
    endtask

    task automatic idle_rx();
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        if (n > 0) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            repeat (n - 1) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic [31:0] cnt);
        check({tag, "_done"},  {31'h0, done},     {31'h0, d});
        check({tag, "_error"}, {31'h0, error},    {31'h0, e});
        check({tag, "_hold"},  {31'h0, cpu_hold}, {31'h0, ~d});
        check({tag, "_count"}, byte_count, cnt);
        check({tag, "_ready"}, {31'h0, bus.rx_ready}, 32'h0);
        $display("%s: done=%b error=%b hold=%b count=%0d", tag, done, error, cpu_hold, byte_count);
    endtask

    task automatic drain(input string tag);
        idle_rx();
        @(negedge clk);
        #1;
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'h0);
    endtask

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",   {31'h0, bus.rx_ready}, 32'h0);
        check("rst_wr_en",   {31'h0, bus.wr_en},    32'h0);
        check("rst_wr_addr", bus.wr_addr,           32'h0);
        check("rst_wr_data", {24'h0, bus.wr_data},  32'h0);
        check_status("rst", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Good image of three bytes.
        pulse_start();
        check("c2_ready_len", {31'h0, bus.rx_ready}, 32'h1);
        send_len(32'd3);
        send_data(0, 8'hB3);
        send_data(1, 8'h00);
        send_data(2, 8'h11);
        send_byte(8'hC4);
        check_status("good", 1'b1, 1'b0, 32'd3);
        drain("good");

        // Same image, wrong checksum.
        pulse_start();
        check("c3_done_clr", {31'h0, done}, 32'h0);
        send_len(32'd3);
        send_data(0, 8'hB3);
        send_data(1, 8'h00);
        send_data(2, 8'h11);
        send_byte(8'hC5);
        check_status("badchk", 1'b0, 1'b1, 32'd3);
        drain("badchk");

        // Oversized length: rejected after the fourth header byte, no writes.
        pulse_start();
        send_len(32'd1025);
        check_status("toolong", 1'b0, 1'b1, 32'd0);
        drain("toolong");

        // Empty image, matching then mismatching checksum.
        pulse_start();
        send_len(32'd0);
        send_byte(8'h00);
        check_status("empty_ok", 1'b1, 1'b0, 32'd0);
        pulse_start();
        send_len(32'd0);
        send_byte(8'h01);
        check_status("empty_bad", 1'b0, 1'b1, 32'd0);
        drain("empty");

        // Stream stall mid-DATA: error exactly after TO idle cycles.
        pulse_start();
        send_len(32'd3);
        send_data(0, 8'hB3);
        idle_rx();
        repeat (TO - 1) @(posedge clk);
        #1;
        check("to_before", {31'h0, error}, 32'h0);
        @(posedge clk);
        #1;
        check("to_after", {31'h0, error}, 32'h1);
        check("to_hold",  {31'h0, cpu_hold}, 32'h1);
        drain("timeout");

        // Random valid gaps plus a Start pulse mid-DATA: same writes as the good case.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            gap($urandom_range(0, 3));
            send_byte(i == 0 ? 8'h03 : 8'h00);
        end
        gap($urandom_range(0, 3));
        send_data(0, 8'hB3);
        pulse_start();
        check("ign_start_busy", {31'h0, bus.rx_ready}, 32'h1);
        gap($urandom_range(0, 3));
        send_data(1, 8'h00);
        gap($urandom_range(0, 3));
        send_data(2, 8'h11);
        gap($urandom_range(0, 3));
        send_byte(8'hC4);
        check_status("gaps", 1'b1, 1'b0, 32'd3);
        drain("gaps");

        // Reset in the middle of DATA.
        pulse_start();
        send_len(32'd4);
        send_data(0, 8'hAA);
        send_data(1, 8'h55);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_wr_en",   {31'h0, bus.wr_en},   32'h0);
        check("mid_wr_addr", bus.wr_addr,          32'h0);
        check("mid_wr_data", {24'h0, bus.wr_data}, 32'h0);
        check("mid_state",   32'(dut.state_reg),   32'(ST_IDLE));
        check_status("midrst", 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("mid_state_hold", 32'(dut.state_reg), 32'(ST_IDLE));
        check("mid_ready_hold", {31'h0, bus.rx_ready}, 32'h0);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drain("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
